// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the 21-bit MIPS core: steps a shared-ALU,
// shared-memory datapath one state per clock, with a req/ack memory port.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] op,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       halt
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_SLTI = 5'b10010;
  localparam logic [4:0] OP_ORI  = 5'b11000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b01100;
  localparam logic [4:0] OP_BEQ  = 5'b01111;
  localparam logic [4:0] OP_J    = 5'b00111;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    REX, IEX, ALUWB, BRANCH, JUMP, HALT
  } state_t;

  state_t state;

  // Memory states only advance on mem_ack; HALT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
    end else begin
      case (state)
        RST:    state <= FETCH;
        FETCH:  if (mem_ack) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW:              state <= MEMADR;
            OP_R:                      state <= REX;
            OP_ADDI, OP_SLTI, OP_ORI:  state <= IEX;
            OP_BEQ:                    state <= BRANCH;
            OP_J:                      state <= JUMP;
            default:                   state <= HALT;
          endcase
        end
        MEMADR: state <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ack) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (mem_ack) state <= FETCH;
        REX:    state <= ALUWB;
        IEX:    state <= ALUWB;
        ALUWB:  state <= FETCH;
        BRANCH: state <= FETCH;
        JUMP:   state <= FETCH;
        HALT:   state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  // Outputs are Mealy where the handshake or branch flag must act in-cycle.
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    ext_op     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    halt       = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ack;
      end
      REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op == OP_ADDI) ? 2'b00 : 2'b11;
        ext_op    = (op != OP_ORI);
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = (op == OP_R);
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// handshake/reset sequences, and random instructions against a micro-program model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       memReq;
    logic       iord;
    logic       memWrite;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       extOp;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       instrDone;
    logic       halt;
  } ctl_t;

  typedef struct {
    logic [4:0] op;
    logic       zero;
    logic       ack;
    ctl_t       exp;
  } vec_t;

  // One model step: outputs when not acked/zero, outputs when acked/zero.
  typedef struct {
    ctl_t idle;
    ctl_t hit;
    bit   waitAck;
    bit   zeroDep;
  } step_t;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_SLTI = 5'b10010;
  localparam logic [4:0] OP_ORI  = 5'b11000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b01100;
  localparam logic [4:0] OP_BEQ  = 5'b01111;
  localparam logic [4:0] OP_J    = 5'b00111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] op = 5'b0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, iord, mem_write, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, ext_op, reg_write, reg_dst, mem_to_reg, instr_done, halt;
  ctl_t       act;

  int errors = 0;
  int checks = 0;
  vec_t  vecs[$];
  step_t prog[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .halt(halt)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, iord, mem_write, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, ext_op, reg_write, reg_dst, mem_to_reg,
                instr_done, halt};

  function automatic ctl_t fetchC(input logic ack);
    ctl_t c = '0;
    c.memReq = 1'b1; c.aluSrcB = 2'b01; c.irWrite = ack; c.pcWrite = ack;
    return c;
  endfunction

  function automatic ctl_t decodeC();
    ctl_t c = '0;
    c.aluSrcB = 2'b11; c.extOp = 1'b1;
    return c;
  endfunction

  function automatic ctl_t memAdrC();
    ctl_t c = '0;
    c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.extOp = 1'b1;
    return c;
  endfunction

  function automatic ctl_t memRdC();
    ctl_t c = '0;
    c.memReq = 1'b1; c.iord = 1'b1;
    return c;
  endfunction

  function automatic ctl_t memWbC();
    ctl_t c = '0;
    c.regWrite = 1'b1; c.memToReg = 1'b1; c.instrDone = 1'b1;
    return c;
  endfunction

  function automatic ctl_t memWrC(input logic ack);
    ctl_t c = '0;
    c.memReq = 1'b1; c.iord = 1'b1; c.memWrite = 1'b1; c.instrDone = ack;
    return c;
  endfunction

  function automatic ctl_t rexC();
    ctl_t c = '0;
    c.aluSrcA = 1'b1; c.aluOp = 2'b10;
    return c;
  endfunction

  function automatic ctl_t iexC(input logic [4:0] o);
    ctl_t c = '0;
    c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
    c.aluOp = (o == OP_ADDI) ? 2'b00 : 2'b11;
    c.extOp = (o == OP_ORI) ? 1'b0 : 1'b1;
    return c;
  endfunction

  function automatic ctl_t aluWbC(input logic isR);
    ctl_t c = '0;
    c.regWrite = 1'b1; c.regDst = isR; c.instrDone = 1'b1;
    return c;
  endfunction

  function automatic ctl_t branchC(input logic z);
    ctl_t c = '0;
    c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcSrc = 2'b01; c.pcWrite = z; c.instrDone = 1'b1;
    return c;
  endfunction

  function automatic ctl_t jumpC();
    ctl_t c = '0;
    c.pcSrc = 2'b10; c.pcWrite = 1'b1; c.instrDone = 1'b1;
    return c;
  endfunction

  function automatic ctl_t haltC();
    ctl_t c = '0;
    c.halt = 1'b1;
    return c;
  endfunction

  function automatic bit isLegal(input logic [4:0] o);
    return (o == OP_R) || (o == OP_ADDI) || (o == OP_SLTI) || (o == OP_ORI) ||
           (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_J);
  endfunction

  task automatic checkOutput(input ctl_t exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge: drive, sample 1 ns later, move to next negedge.
  task automatic applyStimulus(input logic ack, input logic z, input ctl_t exp, input string name);
    mem_ack = ack;
    zero = z;
    #1;
    checkOutput(exp, name);
    @(negedge clk);
  endtask

  task automatic addVec(input logic [4:0] o, input logic z, input logic a, input ctl_t e);
    vec_t v;
    v.op = o; v.zero = z; v.ack = a; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic addStep(input ctl_t idle, input ctl_t hit, input bit waitAck, input bit zeroDep);
    step_t s;
    s.idle = idle; s.hit = hit; s.waitAck = waitAck; s.zeroDep = zeroDep;
    prog.push_back(s);
  endtask

  // Instruction-level model: the ordered micro-steps an opcode walks through.
  task automatic buildProgram(input logic [4:0] o);
    prog.delete();
    addStep(fetchC(1'b0), fetchC(1'b1), 1'b1, 1'b0);
    addStep(decodeC(), decodeC(), 1'b0, 1'b0);
    case (o)
      OP_LW: begin
        addStep(memAdrC(), memAdrC(), 1'b0, 1'b0);
        addStep(memRdC(), memRdC(), 1'b1, 1'b0);
        addStep(memWbC(), memWbC(), 1'b0, 1'b0);
      end
      OP_SW: begin
        addStep(memAdrC(), memAdrC(), 1'b0, 1'b0);
        addStep(memWrC(1'b0), memWrC(1'b1), 1'b1, 1'b0);
      end
      OP_R: begin
        addStep(rexC(), rexC(), 1'b0, 1'b0);
        addStep(aluWbC(1'b1), aluWbC(1'b1), 1'b0, 1'b0);
      end
      OP_ADDI, OP_SLTI, OP_ORI: begin
        addStep(iexC(o), iexC(o), 1'b0, 1'b0);
        addStep(aluWbC(1'b0), aluWbC(1'b0), 1'b0, 1'b0);
      end
      OP_BEQ: addStep(branchC(1'b0), branchC(1'b1), 1'b0, 1'b1);
      OP_J:   addStep(jumpC(), jumpC(), 1'b0, 1'b0);
      default: ;
    endcase
  endtask

  task automatic resetPulse(input string name);
    rst_n = 1'b0;
    #1;
    checkOutput('0, {name, " reset asserted"});
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, '0, {name, " reset held"});
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, {name, " RST after release"});
    applyStimulus(1'b0, 1'b0, fetchC(1'b0), {name, " FETCH after reset"});
  endtask

  initial begin
    // Reset held low: every output zero regardless of mem_ack.
    @(negedge clk);
    for (int k = 0; k < 3; k++) applyStimulus(k[0], 1'b1, '0, "reset hold");
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, "RST cycle");
    applyStimulus(1'b0, 1'b0, fetchC(1'b0), "first FETCH");

    // Directed vectors, mem_ack tied 1, each instruction back to FETCH.
    addVec(OP_ADDI, 0, 1, fetchC(1'b1)); addVec(OP_ADDI, 0, 1, decodeC());
    addVec(OP_ADDI, 0, 1, iexC(OP_ADDI)); addVec(OP_ADDI, 0, 1, aluWbC(1'b0));
    addVec(OP_ORI, 0, 1, fetchC(1'b1));  addVec(OP_ORI, 0, 1, decodeC());
    addVec(OP_ORI, 0, 1, iexC(OP_ORI));  addVec(OP_ORI, 0, 1, aluWbC(1'b0));
    addVec(OP_SLTI, 1, 1, fetchC(1'b1)); addVec(OP_SLTI, 1, 1, decodeC());
    addVec(OP_SLTI, 1, 1, iexC(OP_SLTI)); addVec(OP_SLTI, 1, 1, aluWbC(1'b0));
    addVec(OP_R, 0, 1, fetchC(1'b1));    addVec(OP_R, 0, 1, decodeC());
    addVec(OP_R, 0, 1, rexC());          addVec(OP_R, 0, 1, aluWbC(1'b1));
    addVec(OP_BEQ, 0, 1, fetchC(1'b1));  addVec(OP_BEQ, 0, 1, decodeC());
    addVec(OP_BEQ, 0, 1, branchC(1'b0));
    addVec(OP_BEQ, 1, 1, fetchC(1'b1));  addVec(OP_BEQ, 1, 1, decodeC());
    addVec(OP_BEQ, 1, 1, branchC(1'b1));
    addVec(OP_J, 1, 1, fetchC(1'b1));    addVec(OP_J, 1, 1, decodeC());
    addVec(OP_J, 1, 1, jumpC());
    addVec(OP_J, 0, 0, fetchC(1'b0));
    for (int i = 0; i < vecs.size(); i++) begin
      op = vecs[i].op;
      applyStimulus(vecs[i].ack, vecs[i].zero, vecs[i].exp, $sformatf("vec%0d op=%b", i, vecs[i].op));
    end

    // lw with two wait cycles on both memory accesses: 9 cycles total.
    op = OP_LW;
    applyStimulus(1'b0, 1'b0, fetchC(1'b0), "lw fetch wait1");
    applyStimulus(1'b0, 1'b0, fetchC(1'b0), "lw fetch wait2");
    applyStimulus(1'b1, 1'b0, fetchC(1'b1), "lw fetch ack");
    applyStimulus(1'b0, 1'b0, decodeC(), "lw decode");
    applyStimulus(1'b1, 1'b0, memAdrC(), "lw memadr");
    applyStimulus(1'b0, 1'b0, memRdC(), "lw memrd wait1");
    applyStimulus(1'b0, 1'b0, memRdC(), "lw memrd wait2");
    applyStimulus(1'b1, 1'b0, memRdC(), "lw memrd ack");
    applyStimulus(1'b1, 1'b0, memWbC(), "lw memwb");
    applyStimulus(1'b0, 1'b0, fetchC(1'b0), "lw back to FETCH");

    // sw aborted by reset while MEMWR waits for ack.
    op = OP_SW;
    applyStimulus(1'b1, 1'b0, fetchC(1'b1), "sw fetch");
    applyStimulus(1'b0, 1'b0, decodeC(), "sw decode");
    applyStimulus(1'b0, 1'b0, memAdrC(), "sw memadr");
    applyStimulus(1'b0, 1'b0, memWrC(1'b0), "sw memwr wait");
    mem_ack = 1'b0;
    #1;
    checkOutput(memWrC(1'b0), "sw memwr before reset");
    #2;
    resetPulse("sw abort");

    // Illegal opcode: sticky halt, mem_ack ignored, cleared by reset.
    op = 5'b10101;
    applyStimulus(1'b1, 1'b0, fetchC(1'b1), "illegal fetch");
    applyStimulus(1'b0, 1'b0, decodeC(), "illegal decode");
    for (int k = 0; k < 12; k++) applyStimulus(k[0], ~k[0], haltC(), $sformatf("halt hold %0d", k));
    resetPulse("halt clear");

    // Random instructions with random wait states against the step model.
    for (int n = 0; n < 150; n++) begin
      logic [4:0] iop;
      if ($urandom_range(0, 9) == 0) begin
        do iop = 5'($urandom); while (isLegal(iop));
      end else begin
        case ($urandom_range(0, 7))
          0: iop = OP_R;    1: iop = OP_ADDI; 2: iop = OP_SLTI; 3: iop = OP_ORI;
          4: iop = OP_LW;   5: iop = OP_SW;   6: iop = OP_BEQ;  default: iop = OP_J;
        endcase
      end
      buildProgram(iop);
      op = 5'($urandom);
      for (int s = 0; s < prog.size(); s++) begin
        string nm;
        logic  ack, z;
        int    waits;
        nm = $sformatf("rand n=%0d op=%b step=%0d", n, iop, s);
        waits = 0;
        do begin
          ack = (prog[s].waitAck && waits >= 3) ? 1'b1 : 1'($urandom);
          z = 1'($urandom);
          if (prog[s].waitAck)
            applyStimulus(ack, z, ack ? prog[s].hit : prog[s].idle, nm);
          else if (prog[s].zeroDep)
            applyStimulus(ack, z, z ? prog[s].hit : prog[s].idle, nm);
          else
            applyStimulus(ack, z, prog[s].idle, nm);
          waits++;
        end while (prog[s].waitAck && !ack);
        if (s == 0) op = iop;
      end
      if (!isLegal(iop)) begin
        for (int k = 0; k < 4; k++) applyStimulus(1'($urandom), 1'($urandom), haltC(), $sformatf("rand halt n=%0d", n));
        resetPulse($sformatf("rand n=%0d", n));
        mem_ack = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the 21-bit MIPS core with 5-bit opcodes. It replaces single-cycle decode with a Moore/Mealy FSM that drives a shared-ALU, shared-memory datapath one step per clock. Memory accesses use a req/ack handshake so instruction and data memory can be one port with variable latency. It sits between the instruction register's opcode field and the datapath muxes and enables.

## Interface
- No parameters. Opcode map is fixed: R 00000, addi 00100, slti 10010, ori 11000, lw 01000, sw 01100, beq 01111, j 00111.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  5  opcode from IR; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- mem_write  out  1  write qualifier for mem_req
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 1, 10 extended imm, 11 extended imm (branch offset)
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded (slti/ori)
- ext_op  out  1  1 sign-extend, 0 zero-extend
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file write controls
- instr_done  out  1  one-cycle pulse when an instruction retires
- halt  out  1  sticky illegal-opcode flag

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, IEX, ALUWB, BRANCH, JUMP, HALT.
- Any output not listed for a state is 0.
- RST: entered only by reset; goes to FETCH next cycle.
- FETCH: mem_req=1, iord=0, alu_src_b=01. On mem_ack: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise hold.
- DECODE: alu_src_b=11, ext_op=1 (precompute PC+imm into ALUOut). Next state by op:
  - lw/sw → MEMADR
  - R → REX
  - addi/slti/ori → IEX
  - beq → BRANCH
  - j → JUMP
  - any other op → HALT
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_op=1. lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_ack go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Go to FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1. On mem_ack: instr_done=1, go to FETCH.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- IEX: alu_src_a=1, alu_src_b=10.
  - alu_op=00 for addi, 11 for slti/ori.
  - ext_op=0 for ori, 1 for addi/slti.
  - Go to ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0, reg_dst=1 if op==R else 0, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero, instr_done=1. Go to FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. Go to FETCH.
- HALT: halt=1. Stays in HALT until rst_n is asserted; mem_req=0.

## Timing
- State register updates on posedge clk. rst_n low forces RST immediately, independent of clk.
- Outputs are decoded combinationally from state, plus op, zero and mem_ack where stated. With rst_n low, every output is 0.
- ir_write and pc_write in FETCH, and instr_done in MEMWR, assert only in the cycle mem_ack=1.
- mem_req stays high and iord/mem_write stay stable until mem_ack.
- mem_ack while mem_req=0 is ignored.
- Zero-wait-state cycle counts, FETCH to return to FETCH: lw 5, sw 4, R/addi/slti/ori 4, beq 3, j 3. Each wait cycle on mem_ack adds 1 cycle per memory access.
- Reset mid-instruction aborts the instruction: no pc_write, reg_write or mem_write occurs after rst_n falls. The next FETCH starts 1 cycle after rst_n rises.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0. Release → RST for 1 cycle, then FETCH with mem_req=1, iord=0, alu_src_b=01.
- addi (op=00100), mem_ack tied 1 → states FETCH, DECODE, IEX, ALUWB. ALUWB has reg_write=1, reg_dst=0, ext_op=1 in IEX, instr_done pulse on cycle 4. Repeat with ori (11000) → ext_op=0, alu_op=11.
- lw (01000), mem_ack delayed 2 cycles in both FETCH and MEMRD → 9 cycles total. mem_req held high throughout each wait. ir_write is a single-cycle pulse. MEMWB has mem_to_reg=1.
- beq (01111): zero=0 → pc_write=0 in BRANCH. zero=1 → pc_write=1, pc_src=01. Both take 3 cycles.
- Illegal op 10101 → HALT after DECODE. halt=1 and mem_req=0 for 10+ cycles despite mem_ack toggling. Pulse rst_n → halt clears.
- sw (01100): assert rst_n=0 during MEMWR before mem_ack → mem_write drops the same cycle, no instr_done. After release, FETCH restarts.
